// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared types for the hazard scoreboard: instruction kinds, scoreboard entry
// layout and the "result arrives late" classification.
package hazard_pkg;

    typedef enum logic [1:0] {
        HZ_ALU    = 2'd0,
        HZ_LOAD   = 2'd1,
        HZ_ATOMIC = 2'd2,
        HZ_RSVD   = 2'd3
    } hz_kind_t;

    // Entries carry a fixed-width wsel so the struct stays parameter-free;
    // narrower register indices are zero-extended on the way in.
    localparam int HZ_WSEL_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [HZ_WSEL_W-1:0] wsel;
        hz_kind_t             kind;
    } sb_entry_t;

    function automatic logic is_late(hz_kind_t k);
        return (k == HZ_LOAD) || (k == HZ_ATOMIC);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Decode-side hazard interface: issue info in, stall/flush/forward selects
// and perf counters out.
interface hazard_scoreboard_unit_if #(
    parameter int REG_W   = 5,
    parameter int NSTAGES = 3,
    parameter int NSRC    = 2,
    parameter int CNT_W   = 32
);
    localparam int FW = $clog2(NSTAGES + 1);

    logic                  pipe_en;
    logic                  issue_valid;
    logic                  issue_wen;
    logic [REG_W-1:0]      issue_wsel;
    logic [1:0]            issue_kind;
    logic [NSRC*REG_W-1:0] rsel;
    logic                  pc_mux;
    logic                  halt;
    logic                  stall;
    logic                  flush;
    logic                  halted;
    logic [NSRC*FW-1:0]    fwd_sel;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport slave (
        input  pipe_en, issue_valid, issue_wen, issue_wsel, issue_kind,
               rsel, pc_mux, halt,
        output stall, flush, halted, fwd_sel, stall_cnt, flush_cnt
    );

    modport master (
        output pipe_en, issue_valid, issue_wen, issue_wsel, issue_kind,
               rsel, pc_mux, halt,
        input  stall, flush, halted, fwd_sel, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_scoreboard_unit_hz_src_match.sv
// Per-operand priority search over the scoreboard: youngest matching write
// decides between forwarding from its stage or stalling.
module hz_src_match
    import hazard_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int NSTAGES    = 3,
    parameter int LOAD_READY = 1,
    parameter int FWD_EN     = 1,
    parameter int FW         = $clog2(NSTAGES + 1)
) (
    input  sb_entry_t [NSTAGES-1:0] sb_i,
    input  logic [REG_W-1:0]        rsel_i,
    output logic                    hit_stall_o,
    output logic [FW-1:0]           fwd_sel_o
);
    logic found;
    logic late;
    int   hit_idx;

    always_comb begin
        found       = 1'b0;
        late        = 1'b0;
        hit_idx     = 0;
        hit_stall_o = 1'b0;
        fwd_sel_o   = '0;
        // Scan oldest to youngest so the youngest match overwrites.
        for (int i = NSTAGES - 1; i >= 0; i--) begin
            if (sb_i[i].valid && sb_i[i].wsel == HZ_WSEL_W'(rsel_i)) begin
                found   = 1'b1;
                late    = is_late(sb_i[i].kind);
                hit_idx = i;
            end
        end
        if (found && rsel_i != '0) begin
            if (FWD_EN != 0 && !(late && hit_idx < LOAD_READY))
                fwd_sel_o = FW'(hit_idx + 1);
            else
                hit_stall_o = 1'b1;
        end
    end
endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard/forwarding controller: in-flight write scoreboard that shifts with the
// pipeline, stall/flush generation, sticky halt and saturating perf counters.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int NSTAGES    = 3,
    parameter int NSRC       = 2,
    parameter int LOAD_READY = 1,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 32
) (
    input logic                    CLK,
    input logic                    nRST,
    hazard_scoreboard_unit_if.slave hz
);
    localparam int FW = $clog2(NSTAGES + 1);

    sb_entry_t [NSTAGES-1:0] sb_q, sb_d;
    sb_entry_t               new_e;
    logic                    halted_q, halted_d;
    logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]        flush_cnt_q, flush_cnt_d;
    logic [NSRC-1:0]         hit;
    logic [NSRC-1:0][FW-1:0] fwd;
    logic                    stall, flush;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        hz_src_match #(
            .REG_W(REG_W), .NSTAGES(NSTAGES), .LOAD_READY(LOAD_READY),
            .FWD_EN(FWD_EN), .FW(FW)
        ) u_match (
            .sb_i        (sb_q),
            .rsel_i      (hz.rsel[s*REG_W +: REG_W]),
            .hit_stall_o (hit[s]),
            .fwd_sel_o   (fwd[s])
        );
    end

    // Flush wins: a squashed decode instruction must never also stall.
    assign flush = hz.pc_mux | hz.halt | halted_q;
    assign stall = hz.issue_valid & (|hit) & ~flush;

    always_comb begin
        new_e.valid = hz.issue_wen && (hz.issue_wsel != '0);
        new_e.wsel  = HZ_WSEL_W'(hz.issue_wsel);
        new_e.kind  = hz_kind_t'(hz.issue_kind);

        sb_d        = sb_q;
        halted_d    = halted_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.pipe_en) begin
            for (int k = NSTAGES - 1; k > 0; k--)
                sb_d[k] = sb_q[k-1];
            sb_d[0]  = (stall || flush || !hz.issue_valid) ? '0 : new_e;
            halted_d = halted_q | hz.halt;
            if (stall && stall_cnt_q != '1)
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush && flush_cnt_q != '1)
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sb_q        <= '0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall     = stall;
    assign hz.flush     = flush;
    assign hz.halted    = halted_q;
    assign hz.fwd_sel   = fwd;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
endmodule
